// File: rtl/pwm_gen_pkg.sv
// ---------------------------------------------------------------------------
// pwm_gen_pkg
//   Shared types, constants and edge math for the multi-channel PWM generator.
//   calc_edges() turns a DUTY/PHASE/CYCLE triple into the rising and falling
//   counter values of a pulse centred on PHASE, with any odd extra tick placed
//   after the centre.
// ---------------------------------------------------------------------------
package pwm_gen_pkg;

  localparam int unsigned PWM_WIDTH = 13;
  localparam int unsigned PWM_DEPTH = 249;
  localparam int unsigned MIN_CYCLE = 2;

  typedef logic [PWM_WIDTH-1:0] cycle_t;
  typedef logic [PWM_WIDTH-1:0] duty_t;
  typedef logic [PWM_WIDTH-1:0] phase_t;

  // One extra bit so the subtraction/addition can over- or under-flow visibly.
  typedef logic [PWM_WIDTH:0] ext_t;

  typedef struct packed {
    phase_t rise;
    phase_t fall;
  } edges_t;

  // rise = PHASE - floor(DUTY/2), fall = PHASE + ceil(DUTY/2), both wrapped
  // once into [0, CYCLE). Valid for PHASE < CYCLE and DUTY < CYCLE; the other
  // cases are handled by the caller (constant 0/1 output).
  function automatic edges_t calc_edges(input cycle_t i_cyc,
                                        input duty_t  i_duty,
                                        input phase_t i_phase);
    ext_t   w_rise;
    ext_t   w_fall;
    edges_t w_e;
    w_rise = ext_t'(i_phase) - ext_t'(i_duty >> 1);
    if (w_rise[PWM_WIDTH]) begin
      w_rise = w_rise + ext_t'(i_cyc);
    end
    w_fall = ext_t'(i_phase) + ((ext_t'(i_duty) + ext_t'(1)) >> 1);
    if (w_fall >= ext_t'(i_cyc)) begin
      w_fall = w_fall - ext_t'(i_cyc);
    end
    w_e.rise = phase_t'(w_rise);
    w_e.fall = phase_t'(w_fall);
    return w_e;
  endfunction

  // A period shorter than two ticks has no room for a wrap; force it to two.
  function automatic cycle_t clamp_cycle(input cycle_t i_cyc);
    return (i_cyc < cycle_t'(MIN_CYCLE)) ? cycle_t'(MIN_CYCLE) : i_cyc;
  endfunction

endpackage

// File: rtl/pwm_gen_channel.sv
// ---------------------------------------------------------------------------
// pwm_gen_channel
//   One PWM channel: free-running counter modulo its active CYCLE, a pending
//   (double-buffered) settings set that is promoted at the period boundary or
//   on SYNC, pre-computed rise/fall edges, and a registered compare output.
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_sync            realign counter to 0 on the next edge; promotes pending
//   i_update          capture i_cycle/i_duty/i_phase into the pending set
//   i_cycle/duty/phase new settings (ticks)
//   o_pwm             registered PWM output (1 clk after the counter value)
//   o_err             sticky: an activation carried PHASE >= CYCLE
// ---------------------------------------------------------------------------
module pwm_gen_channel
  import pwm_gen_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sync,
  input  logic                 i_update,
  input  logic [PWM_WIDTH-1:0] i_cycle,
  input  logic [PWM_WIDTH-1:0] i_duty,
  input  logic [PWM_WIDTH-1:0] i_phase,
  output logic                 o_pwm,
  output logic                 o_err
);

  logic [PWM_WIDTH-1:0] r_cnt;
  logic [PWM_WIDTH-1:0] r_cyc;
  logic [PWM_WIDTH-1:0] r_duty;
  logic [PWM_WIDTH-1:0] r_rise;
  logic [PWM_WIDTH-1:0] r_fall;

  logic                 r_pend_valid;
  logic [PWM_WIDTH-1:0] r_pend_cyc;
  logic [PWM_WIDTH-1:0] r_pend_duty;
  logic [PWM_WIDTH-1:0] r_pend_phase;

  logic                 r_pwm;
  logic                 r_err;

  logic                 w_wrap;
  logic                 w_activate;
  logic                 w_phase_bad;
  logic                 w_pwm_c;
  edges_t               w_edges;

  assign w_wrap      = (r_cnt == (r_cyc - cycle_t'(1)));
  // Uses the pending set as it stood before this edge, so an UPDATE arriving
  // together with a wrap or SYNC only lines up for the next boundary.
  assign w_activate  = r_pend_valid & (w_wrap | i_sync);
  assign w_phase_bad = (r_pend_phase >= r_pend_cyc);
  assign w_edges     = calc_edges(r_pend_cyc, r_pend_duty, r_pend_phase);

  // Period counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_sync || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + cycle_t'(1);
    end
  end

  // Pending settings; a fresh UPDATE always wins over clearing on activation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_valid <= 1'b0;
      r_pend_cyc   <= cycle_t'(MIN_CYCLE);
      r_pend_duty  <= '0;
      r_pend_phase <= '0;
    end else if (i_update) begin
      r_pend_valid <= 1'b1;
      r_pend_cyc   <= clamp_cycle(i_cycle);
      r_pend_duty  <= i_duty;
      r_pend_phase <= i_phase;
    end else if (w_activate) begin
      r_pend_valid <= 1'b0;
    end
  end

  // Active settings and sticky configuration error
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cyc  <= cycle_t'(MIN_CYCLE);
      r_duty <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_err  <= 1'b0;
    end else if (w_activate) begin
      r_cyc  <= r_pend_cyc;
      r_rise <= w_edges.rise;
      r_fall <= w_edges.fall;
      if (w_phase_bad) begin
        // Out-of-range centre: mute the channel rather than emit a bad pulse
        r_duty <= '0;
        r_err  <= 1'b1;
      end else begin
        r_duty <= r_pend_duty;
      end
    end
  end

  // Compare: plain window when rise <= fall, otherwise the pulse straddles 0
  always_comb begin
    w_pwm_c = 1'b0;
    if (r_duty == '0) begin
      w_pwm_c = 1'b0;
    end else if (r_duty >= r_cyc) begin
      w_pwm_c = 1'b1;
    end else if (r_rise <= r_fall) begin
      w_pwm_c = (r_cnt >= r_rise) && (r_cnt < r_fall);
    end else begin
      w_pwm_c = (r_cnt >= r_rise) || (r_cnt < r_fall);
    end
  end

  // Output register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_pwm_c;
    end
  end

  assign o_pwm = r_pwm;
  assign o_err = r_err;

endmodule

// File: rtl/pwm_gen_multi.sv
// ---------------------------------------------------------------------------
// pwm_gen_multi
//   Multi-channel PWM generator, each channel with its own carrier period.
//   Fans UPDATE/SYNC out to DEPTH channels and merges their error flags.
//   WIDTH must equal pwm_gen_pkg::PWM_WIDTH (edge math is typed on it).
// Ports
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_sync      1-clk pulse, realigns all channel counters
//   i_update    1-clk pulse, captures all channel settings into pending regs
//   i_cycle     WIDTH x DEPTH per-channel period (channel n at [n*WIDTH +: WIDTH])
//   i_duty      WIDTH x DEPTH per-channel high time
//   i_phase     WIDTH x DEPTH per-channel pulse centre
//   o_pwm_out   DEPTH registered PWM outputs
//   o_cfg_err   sticky, set once any channel activated with PHASE >= CYCLE
// ---------------------------------------------------------------------------
module pwm_gen_multi
  import pwm_gen_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH,
  parameter int unsigned DEPTH = PWM_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sync,
  input  logic                   i_update,
  input  logic [WIDTH*DEPTH-1:0] i_cycle,
  input  logic [WIDTH*DEPTH-1:0] i_duty,
  input  logic [WIDTH*DEPTH-1:0] i_phase,
  output logic [DEPTH-1:0]       o_pwm_out,
  output logic                   o_cfg_err
);

  logic [DEPTH-1:0] w_err;
  logic             r_cfg_err;

  // Channel array
  for (genvar g = 0; g < DEPTH; g++) begin : g_ch
    pwm_gen_channel u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_sync   (i_sync),
      .i_update (i_update),
      .i_cycle  (i_cycle[g*WIDTH +: WIDTH]),
      .i_duty   (i_duty[g*WIDTH +: WIDTH]),
      .i_phase  (i_phase[g*WIDTH +: WIDTH]),
      .o_pwm    (o_pwm_out[g]),
      .o_err    (w_err[g])
    );
  end

  // Registered OR of the (already sticky) channel flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= r_cfg_err | (|w_err);
    end
  end

  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_gen_multi
//   Directed bench for pwm_gen_multi with a per-channel behavioural model.
//   The model tracks counter/active/pending state and derives each output bit
//   as "(cnt - rise) mod cycle < duty", independent of the rise/fall compare.
// ---------------------------------------------------------------------------
module tb_pwm_gen_multi;
  import pwm_gen_pkg::*;

  localparam int unsigned WIDTH = PWM_WIDTH;
  localparam int unsigned DEPTH = PWM_DEPTH;
  typedef logic [WIDTH-1:0] val_t;

  logic                   tb_clk = 1'b0;
  logic                   tb_rst;
  logic                   tb_sync;
  logic                   tb_update;
  logic [WIDTH*DEPTH-1:0] tb_cycle;
  logic [WIDTH*DEPTH-1:0] tb_duty;
  logic [WIDTH*DEPTH-1:0] tb_phase;
  logic [DEPTH-1:0]       tb_pwm;
  logic                   tb_cfg_err;

  always #5 tb_clk = ~tb_clk;

  pwm_gen_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .i_clk     (tb_clk),
    .i_rst     (tb_rst),
    .i_sync    (tb_sync),
    .i_update  (tb_update),
    .i_cycle   (tb_cycle),
    .i_duty    (tb_duty),
    .i_phase   (tb_phase),
    .o_pwm_out (tb_pwm),
    .o_cfg_err (tb_cfg_err)
  );

  // model state
  int m_cnt [DEPTH];
  int m_cyc [DEPTH];
  int m_duty [DEPTH];
  int m_phase [DEPTH];
  bit m_pv [DEPTH];
  int m_pcyc [DEPTH];
  int m_pduty [DEPTH];
  int m_pphase [DEPTH];
  bit m_err [DEPTH];
  logic [DEPTH-1:0] exp_pwm;
  logic             exp_err;

  int n_checks;
  int n_fail;
  int n_shown;
  int hi [8192];
  int hi_cnt;

  function automatic bit model_level(input int cnt, input int cyc, input int duty, input int phase);
    int rise;
    if (duty == 0) return 1'b0;
    if (duty >= cyc) return 1'b1;
    rise = ((phase - duty / 2) % cyc + cyc) % cyc;
    return (((cnt - rise) % cyc + cyc) % cyc) < duty;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    bit wrap;
    bit act;
    int c_in;
    if (tb_rst) begin
      for (int c = 0; c < DEPTH; c++) begin
        m_cnt[c] = 0; m_cyc[c] = 2; m_duty[c] = 0; m_phase[c] = 0;
        m_pv[c] = 1'b0; m_pcyc[c] = 2; m_pduty[c] = 0; m_pphase[c] = 0;
        m_err[c] = 1'b0;
      end
      exp_pwm = '0;
      exp_err = 1'b0;
      return;
    end
    for (int c = 0; c < DEPTH; c++) begin
      if (m_err[c]) exp_err = 1'b1;
    end
    for (int c = 0; c < DEPTH; c++) begin
      wrap = (m_cnt[c] == m_cyc[c] - 1);
      act  = m_pv[c] && (wrap || tb_sync);
      exp_pwm[c] = model_level(m_cnt[c], m_cyc[c], m_duty[c], m_phase[c]);
      m_cnt[c] = (wrap || tb_sync) ? 0 : m_cnt[c] + 1;
      if (act) begin
        m_pv[c]    = 1'b0;
        m_cyc[c]   = m_pcyc[c];
        m_phase[c] = m_pphase[c];
        if (m_pphase[c] >= m_pcyc[c]) begin
          m_duty[c] = 0;
          m_err[c]  = 1'b1;
        end else begin
          m_duty[c] = m_pduty[c];
        end
      end
      if (tb_update) begin
        c_in = int'(tb_cycle[c*WIDTH +: WIDTH]);
        m_pv[c]     = 1'b1;
        m_pcyc[c]   = (c_in < 2) ? 2 : c_in;
        m_pduty[c]  = int'(tb_duty[c*WIDTH +: WIDTH]);
        m_pphase[c] = int'(tb_phase[c*WIDTH +: WIDTH]);
      end
    end
  endtask

  // One clock: model follows the rising edge, outputs compared at the falling edge.
  task automatic tick();
    int first;
    @(posedge tb_clk);
    model_step();
    @(negedge tb_clk);
    if (!tb_rst) begin
      n_checks++;
      if (tb_pwm !== exp_pwm) begin
        n_fail++;
        first = -1;
        for (int c = 0; c < DEPTH; c++) begin
          if (first < 0 && tb_pwm[c] !== exp_pwm[c]) first = c;
        end
        if (n_shown < 10) $display("FAIL pwm_vs_model t=%0t ch%0d got %b expected %b",
                                   $time, first, tb_pwm[first], exp_pwm[first]);
        n_shown++;
      end
      n_checks++;
      if (tb_cfg_err !== exp_err) begin
        n_fail++;
        if (n_shown < 10) $display("FAIL cfg_err_vs_model t=%0t got %b expected %b",
                                   $time, tb_cfg_err, exp_err);
        n_shown++;
      end
    end
  endtask

  task automatic set_ch(input int ch, input int cyc, input int duty, input int phase);
    tb_cycle[ch*WIDTH +: WIDTH] = val_t'(cyc);
    tb_duty[ch*WIDTH +: WIDTH]  = val_t'(duty);
    tb_phase[ch*WIDTH +: WIDTH] = val_t'(phase);
  endtask

  // UPDATE, then SYNC; on return the next tick shows cnt = 0.
  task automatic pulse_upd_sync();
    tb_update = 1'b1;
    tick();
    tb_update = 1'b0;
    tb_sync   = 1'b1;
    tick();
    tb_sync   = 1'b0;
  endtask

  // Record ch output for n ticks; optional UPDATE pulses (new duty) at two indices.
  task automatic capture(input int ch, input int n, input int ua0, input int ud0,
                         input int ua1, input int ud1);
    hi_cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      hi[k] = int'(tb_pwm[ch]);
      hi_cnt += hi[k];
      tb_update = 1'b0;
      if (k == ua0) begin
        tb_duty[ch*WIDTH +: WIDTH] = val_t'(ud0);
        tb_update = 1'b1;
      end
      if (k == ua1) begin
        tb_duty[ch*WIDTH +: WIDTH] = val_t'(ud1);
        tb_update = 1'b1;
      end
    end
    tb_update = 1'b0;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    edges_t e;
    int r0;
    int r1;
    n_checks = 0;
    n_fail   = 0;
    n_shown  = 0;
    tb_rst    = 1'b1;
    tb_sync   = 1'b0;
    tb_update = 1'b0;
    for (int c = 0; c < DEPTH; c++) set_ch(c, 4096, 0, 0);

    // literal pins for the shared edge function and the model
    e = calc_edges(val_t'(4096), val_t'(400), val_t'(100));
    check("edges_400_100_rise", int'(e.rise), 3996);
    check("edges_400_100_fall", int'(e.fall), 300);
    e = calc_edges(val_t'(4096), val_t'(2048), val_t'(0));
    check("edges_2048_0_rise", int'(e.rise), 3072);
    check("edges_2048_0_fall", int'(e.fall), 1024);
    e = calc_edges(val_t'(4096), val_t'(1), val_t'(7));
    check("edges_1_7_fall", int'(e.fall), 8);
    check("model_3996_high", int'(model_level(3996, 4096, 400, 100)), 1);
    check("model_3995_low",  int'(model_level(3995, 4096, 400, 100)), 0);
    check("model_300_low",   int'(model_level(300, 4096, 400, 100)), 0);

    repeat (3) tick();
    check("reset_pwm_zero", int'(tb_pwm == '0), 1);
    check("reset_cfg_err",  int'(tb_cfg_err), 0);
    tb_rst = 1'b0;
    repeat (5) tick();

    // 1: reset mid-pulse
    set_ch(0, 4096, 2048, 0);
    pulse_upd_sync();
    repeat (100) tick();
    check("t1_high_before_rst", int'(tb_pwm[0]), 1);
    #2 tb_rst = 1'b1;
    #1 check("t1_rst_immediate", int'(tb_pwm[0]), 0);
    tick();
    tick();
    tb_rst = 1'b0;
    capture(0, 4500, -1, 0, -1, 0);
    check("t1_low_after_rst", hi_cnt, 0);

    // 2: centred half-duty pulse around 0
    pulse_upd_sync();
    capture(0, 4096, -1, 0, -1, 0);
    check("t2_high_count", hi_cnt, 2048);
    check("t2_cnt0",    hi[0], 1);
    check("t2_cnt1023", hi[1023], 1);
    check("t2_cnt1024", hi[1024], 0);
    check("t2_cnt3071", hi[3071], 0);
    check("t2_cnt3072", hi[3072], 1);

    // 3: wrap-around pulse, then single-tick pulse
    set_ch(0, 4096, 400, 100);
    pulse_upd_sync();
    capture(0, 4096, -1, 0, -1, 0);
    check("t3_wrap_count", hi_cnt, 400);
    check("t3_cnt299",  hi[299], 1);
    check("t3_cnt300",  hi[300], 0);
    check("t3_cnt3995", hi[3995], 0);
    check("t3_cnt3996", hi[3996], 1);
    set_ch(0, 4096, 1, 7);
    pulse_upd_sync();
    capture(0, 4096, -1, 0, -1, 0);
    check("t3_single_count", hi_cnt, 1);
    check("t3_single_cnt7", hi[7], 1);

    // 4: mid-period update, duty 0 / full, update on the wrap
    set_ch(0, 4096, 2048, 0);
    pulse_upd_sync();
    capture(0, 4096, 1000, 0, -1, 0);
    check("t4_old_until_wrap", hi_cnt, 2048);
    check("t4_old_cnt3072", hi[3072], 1);
    capture(0, 4096, -1, 0, -1, 0);
    check("t4_duty0_const", hi_cnt, 0);
    capture(0, 4096, 99, 1000, 4094, 4096);
    check("t4_pending_period", hi_cnt, 0);
    capture(0, 4096, -1, 0, -1, 0);
    check("t4_prev_pending_at_wrap", hi_cnt, 1000);
    capture(0, 4096, -1, 0, -1, 0);
    check("t4_full_duty_const", hi_cnt, 4096);

    // 5: independent periods and SYNC alignment
    set_ch(0, 4096, 1, 0);
    set_ch(1, 2000, 1, 0);
    pulse_upd_sync();
    tick();
    check("t5_sync_ch0", int'(tb_pwm[0]), 1);
    check("t5_sync_ch1", int'(tb_pwm[1]), 1);
    r0 = -1;
    r1 = -1;
    for (int k = 1; k < 4200; k++) begin
      tick();
      if (tb_pwm[0] && r0 < 0) r0 = k;
      if (tb_pwm[1] && r1 < 0) r1 = k;
    end
    check("t5_period_ch0", r0, 4096);
    check("t5_period_ch1", r1, 2000);

    // random settings on every channel, checked against the model
    for (int c = 0; c < DEPTH; c++) begin
      set_ch(c, 4096, int'($urandom_range(2048)), int'($urandom_range(4095)));
    end
    pulse_upd_sync();
    repeat (4200) tick();
    check("t5_no_cfg_err", int'(tb_cfg_err), 0);

    // 6: illegal phase mutes the channel; error is sticky
    set_ch(5, 4096, 100, 4096);
    pulse_upd_sync();
    capture(5, 4096, -1, 0, -1, 0);
    check("t6_muted", hi_cnt, 0);
    check("t6_cfg_err_set", int'(tb_cfg_err), 1);
    set_ch(5, 4096, 100, 10);
    pulse_upd_sync();
    capture(5, 4096, -1, 0, -1, 0);
    check("t6_legal_count", hi_cnt, 100);
    check("t6_cnt59",   hi[59], 1);
    check("t6_cnt60",   hi[60], 0);
    check("t6_cnt4056", hi[4056], 1);
    check("t6_cfg_err_sticky", int'(tb_cfg_err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
